// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes and execution-unit state encoding.
package alu_pkg;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
endpackage

// File: rtl/alu_comb_core.sv
// alu_comb_core: single-cycle ALU ops; codes without a single-cycle op (incl. mul) flag illegal.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);
  always_comb begin
    illegal = 1'b0;
    case (code)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_XOR: result = a ^ b;
      ALU_NOR: result = ~(a | b);
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      default: begin
        result  = '0;
        illegal = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked ALU execution stage; define ALU_MUL_EN to enable the
// iterative shift-add multiply on code 101 (otherwise 101 completes as illegal).
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       gout,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal_op
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] core_res;
  logic             core_ill;

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .code    (gout),
    .a       (a),
    .b       (b),
    .result  (core_res),
    .illegal (core_ill)
  );

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
`ifdef ALU_MUL_EN
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifdef ALU_MUL_EN
          if (gout == ALU_MUL) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL;
          end else begin
            result_d  = core_res;
            zero_d    = core_res == '0;
            illegal_d = core_ill;
            state_d   = DONE;
          end
`else
          result_d  = core_res;
          zero_d    = core_res == '0;
          illegal_d = core_ill;
          state_d   = DONE;
`endif
        end
      end
`ifdef ALU_MUL_EN
      MUL: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          result_d  = acc_d;
          zero_d    = acc_d == '0;
          illegal_d = 1'b0;
          state_d   = DONE;
        end
      end
`endif
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready   = state_q == IDLE;
  assign out_valid  = state_q == DONE;
  assign result     = result_q;
  assign zero       = zero_q;
  assign illegal_op = illegal_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized checks against an arithmetic reference model.
module tb_alu_exec_unit;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  gout = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        illegal_op;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .gout       (gout),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .illegal_op (illegal_op)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
    case (c)
      3'b000:  return {1'b0, x & y};
      3'b001:  return {1'b0, x | y};
      3'b010:  return {1'b0, x + y};
      3'b011:  return {1'b0, x ^ y};
      3'b100:  return {1'b0, ~(x | y)};
      3'b110:  return {1'b0, x - y};
      3'b111:  return {1'b0, 31'b0, $signed(x) < $signed(y)};
      default: return MUL_EN ? {1'b0, x * y} : {1'b1, 32'h0};
    endcase
  endfunction

  task automatic run_op(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y, input int hold);
    logic [32:0] e;
    logic [31:0] r0;
    int lat, n, exp_lat;
    logic bad;
    e = model(c, x, y);
    exp_lat = (c == 3'b101 && MUL_EN) ? 33 : 1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {31'b0, in_ready}, 32'd1);
    gout = c;
    a = x;
    b = y;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    lat = 0;
    bad = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      in_valid = 1'b0;
      if (!out_valid && in_ready) bad = 1'b1;
    end while (!out_valid && lat < 200);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("busy_ready", {31'b0, bad}, 32'd0);
    chk("result", result, e[31:0]);
    chk("zero", {31'b0, zero}, {31'b0, e[31:0] == 32'd0});
    chk("illegal", {31'b0, illegal_op}, {31'b0, e[32]});
    chk("done_ready", {31'b0, in_ready}, 32'd0);
    r0 = result;
    bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      gout = 3'($urandom);
      a = $urandom;
      b = $urandom;
      in_valid = 1'b1;
      @(negedge clk);
      if (!out_valid || result !== r0 || in_ready) bad = 1'b1;
    end
    in_valid = 1'b0;
    if (hold > 0) chk("hold_stable", {31'b0, bad}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("back_idle", {30'b0, out_valid, in_ready}, 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] x, y;
    logic bad;
    #2;
    chk("rst_outs", {29'b0, out_valid, zero, illegal_op}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op(3'b010, 32'hFFFF_FFFF, 32'h1, 0);
    run_op(3'b111, 32'hFFFF_FFFE, 32'h1, 0);
    run_op(3'b110, 32'd5, 32'd5, 0);
    run_op(3'b100, 32'h0F0F_0F0F, 32'h00FF_00FF, 0);
    run_op(3'b011, 32'h0F0F_0F0F, 32'h00FF_00FF, 0);
    run_op(3'b101, 32'd123, 32'd456, 0);
    run_op(3'b010, 32'd3, 32'd4, 5);
    run_op(3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 1);
    for (int k = 0; k < 40; k++) begin
      x = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      y = ($urandom_range(0, 3) == 0) ? x : $urandom;
      run_op(3'($urandom), x, y, $urandom_range(0, 2));
    end
    // abort: async reset while busy must clear everything without waiting for a clock
    gout = MUL_EN ? 3'b101 : 3'b001;
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_outs", {29'b0, out_valid, zero, illegal_op}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) bad = 1'b1;
    end
    chk("abort_no_out", {31'b0, bad}, 32'd0);
    run_op(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'b000, 32'hF0F0_1234, 32'h0F0F_4321, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
